// File: rtl/tx_arbiter.sv
// tx_arbiter: two-source packet arbiter feeding a UART TX core
//   Purpose : locks the UART to one byte stream (CPU console or debug trace)
//             for a whole packet and alternates owners when both are waiting.
//   Ports   : i_clk            sole clock, rising edge
//             i_rst_n          asynchronous active-low reset
//             i_en             allows new grants (never aborts a packet)
//             i_cpu_valid/i_cpu_data/i_cpu_last, o_cpu_ready  CPU stream
//             i_dbg_valid/i_dbg_data/i_dbg_last, o_dbg_ready  debug stream
//             o_tx_stb/o_tx_data, i_tx_busy                   UART TX core
//             o_owner          00 none, 01 CPU, 10 debug
//             o_timeout        one-cycle pulse on a forced lock release
//   Option  : define TX_ARB_TIMEOUT_EN to release a stalled lock after
//             TIMEOUT cycles without owner valid; otherwise a lock is held
//             until the owner's last byte and o_timeout is tied low.
module tx_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_cpu_valid,
    input  logic [7:0] i_cpu_data,
    input  logic       i_cpu_last,
    output logic       o_cpu_ready,
    input  logic       i_dbg_valid,
    input  logic [7:0] i_dbg_data,
    input  logic       i_dbg_last,
    output logic       o_dbg_ready,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy,
    output logic [1:0] o_owner,
    output logic       o_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("tx_arbiter: TIMEOUT must be at least 1");
    end

    state_t     state, state_nx;
    logic [1:0] owner_nx;
    logic       stb_nx;
    logic [7:0] data_nx;
    logic       prio, prio_nx;     // 1: debug wins a tie, 0: CPU wins
    logic       last_q, last_nx;   // last flag of the byte currently in flight
    logic       own_valid, own_last, send_ok, xfer, tmo_hit;
    logic [7:0] own_data;

    assign own_valid   = (o_owner == OWN_CPU && i_cpu_valid) || (o_owner == OWN_DBG && i_dbg_valid);
    assign own_data    = (o_owner == OWN_DBG) ? i_dbg_data : i_cpu_data;
    assign own_last    = (o_owner == OWN_DBG) ? i_dbg_last : i_cpu_last;
    assign send_ok     = (state == S_SEND) && !i_tx_busy;
    assign o_cpu_ready = send_ok && (o_owner == OWN_CPU);
    assign o_dbg_ready = send_ok && (o_owner == OWN_DBG);
    assign xfer        = send_ok && own_valid;

`ifdef TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;

    // Release on the edge at which the stall count would reach TIMEOUT.
    assign tmo_hit = (state == S_SEND) && !own_valid && (idle_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            idle_cnt  <= (state == S_SEND && !own_valid && !tmo_hit) ? idle_cnt + CW'(1) : '0;
            o_timeout <= tmo_hit;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            o_owner   <= OWN_NONE;
            o_tx_stb  <= 1'b0;
            o_tx_data <= 8'h00;
            prio      <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            o_owner   <= owner_nx;
            o_tx_stb  <= stb_nx;
            o_tx_data <= data_nx;
            prio      <= prio_nx;
            last_q    <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = o_owner;
        stb_nx   = 1'b0;
        data_nx  = o_tx_data;
        prio_nx  = prio;
        last_nx  = last_q;
        case (state)
            S_IDLE: begin
                if (i_en && (i_cpu_valid || i_dbg_valid)) begin
                    state_nx = S_SEND;
                    owner_nx = (i_cpu_valid && (!i_dbg_valid || !prio)) ? OWN_CPU : OWN_DBG;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    state_nx = S_WAIT;
                    stb_nx   = 1'b1;
                    data_nx  = own_data;
                    last_nx  = own_last;
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                    owner_nx = OWN_NONE;
                    prio_nx  = (o_owner == OWN_CPU);
                end
            end
            S_WAIT: begin
                // busy only rises the cycle after the strobe, so the strobe
                // cycle itself must never count as "UART idle"
                if (!o_tx_stb && !i_tx_busy) begin
                    state_nx = last_q ? S_IDLE : S_SEND;
                    owner_nx = last_q ? OWN_NONE : o_owner;
                    prio_nx  = last_q ? (o_owner == OWN_CPU) : prio;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: randomized and directed checks of tx_arbiter against a packet-level model
module tb_tx_arbiter;
`ifdef TX_ARB_TIMEOUT_EN
    localparam int TMO     = 8;
    localparam int EXP_TMO = 1;
`else
    localparam int TMO     = 1024;
    localparam int EXP_TMO = 0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, tx_busy = 1'b0;
    logic       vld [2];
    logic [7:0] dat [2];
    logic       lst [2];
    logic       cpu_ready, dbg_ready, tx_stb, timeout;
    logic [7:0] tx_data;
    logic [1:0] owner;

    int n_checks = 0, n_fail = 0, bad_ready = 0, n_tmo = 0, busy_len = 3;
    bit busy_rnd = 1'b0;

    logic [9:0] exp_q [$];
    logic [7:0] pd [2][8][8];
    int         pl [2][8];
    int         np [2];

    always #5 clk = ~clk;

    tx_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_cpu_valid(vld[0]), .i_cpu_data(dat[0]), .i_cpu_last(lst[0]), .o_cpu_ready(cpu_ready),
        .i_dbg_valid(vld[1]), .i_dbg_data(dat[1]), .i_dbg_last(lst[1]), .o_dbg_ready(dbg_ready),
        .o_tx_stb(tx_stb), .o_tx_data(tx_data), .i_tx_busy(tx_busy),
        .o_owner(owner), .o_timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Every strobe must be the next byte the packet-level model predicts.
    always @(negedge clk) begin : monitor
        logic [9:0] e;
        if (rst_n) begin
            if ((cpu_ready && owner != 2'b01) || (dbg_ready && owner != 2'b10) || (cpu_ready && dbg_ready))
                bad_ready++;
            if (timeout) n_tmo++;
            if (tx_stb) begin
                if (exp_q.size() == 0) check("stray_stb", 32'(tx_data), 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e[7:0]));
                    check("tx_owner", 32'(owner), 32'(e[9:8]));
                end
            end
        end
    end

    // UART: busy rises the cycle after a strobe and stays high for len cycles.
    initial begin : uart
        int len;
        forever begin
            @(negedge clk);
            if (tx_stb && rst_n) begin
                len = busy_rnd ? int'($urandom_range(5, 1)) : busy_len;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic add_pkt(input int s, input int len, input logic [63:0] w);
        pl[s][np[s]] = len;
        for (int b = 0; b < len; b++) pd[s][np[s]][b] = w[8*b +: 8];
        np[s]++;
    endtask

    task automatic clear_pkts();
        np[0] = 0;
        np[1] = 0;
    endtask

    // Whole packets, never interleaved; when both sources still have packets
    // the one not served last goes next, starting from source 'first'.
    task automatic model_arb(input int first);
        int idx [2];
        int turn, s;
        idx[0] = 0;
        idx[1] = 0;
        turn = first;
        while (idx[0] < np[0] || idx[1] < np[1]) begin
            s = (idx[turn] < np[turn]) ? turn : 1 - turn;
            for (int b = 0; b < pl[s][idx[s]]; b++)
                exp_q.push_back({(s == 0) ? 2'b01 : 2'b10, pd[s][idx[s]][b]});
            idx[s]++;
            turn = 1 - s;
        end
    endtask

    task automatic send_pkt(input int s, input int k, input int from, input int to, input int max_gap);
        int n;
        for (int b = from; b < to; b++) begin
            vld[s] = 1'b1;
            dat[s] = pd[s][k][b];
            lst[s] = (b == pl[s][k] - 1);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!((s == 0) ? cpu_ready : dbg_ready) && n < 3000);
            if (n >= 3000) check("handshake_timeout", 32'(s), 32'hFFFF_FFFF);
            @(posedge clk);
            #1 vld[s] = 1'b0;
            if (b < to - 1 && max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_all(input int max_gap);
        fork
            for (int k = 0; k < np[0]; k++) send_pkt(0, k, 0, pl[0][k], max_gap);
            for (int k = 0; k < np[1]; k++) send_pkt(1, k, 0, pl[1][k], max_gap);
        join
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (owner != 2'b00 && n < 300);
        check(tag, 32'(owner), 32'd0);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n, d;
        vld[0] = 1'b0; vld[1] = 1'b0; dat[0] = 8'h00; dat[1] = 8'h00; lst[0] = 1'b0; lst[1] = 1'b0;
        clear_pkts();
        // requests during reset get neither ready nor a grant
        en = 1'b1; vld[0] = 1'b1; vld[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_stb", 32'(tx_stb), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_dbg_ready", 32'(dbg_ready), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        vld[0] = 1'b0; vld[1] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // "OK\n" from the CPU, 10-cycle busy, with grant/strobe latency
        busy_len = 10;
        clear_pkts();
        add_pkt(0, 3, 64'h0A4B4F);
        model_arb(0);
        fork
            send_pkt(0, 0, 0, 3, 0);
            begin
                @(posedge clk);
                #2 check("lat_owner", 32'(owner), 32'd1);
                check("lat_cpu_ready", 32'(cpu_ready), 32'd1);
                check("lat_dbg_ready", 32'(dbg_ready), 32'd0);
                @(posedge clk);
                #2 check("lat_stb", 32'(tx_stb), 32'd1);
                check("lat_data", 32'(tx_data), 32'h4F);
            end
        join
        check("ok_owner_hold", 32'(owner), 32'd1);
        wait_idle("ok_owner_idle");
        check("ok_busy_low", 32'(tx_busy), 32'd0);
        check("ok_drain", 32'(exp_q.size()), 32'd0);

        // simultaneous requests after reset: CPU, debug, CPU, debug
        busy_len = 2;
        do_reset();
        clear_pkts();
        add_pkt(0, 2, 64'hA2A1);
        add_pkt(0, 1, 64'hA3);
        add_pkt(1, 3, 64'hB3B2B1);
        add_pkt(1, 2, 64'hB5B4);
        model_arb(0);
        run_all(0);
        wait_idle("alt_idle");
        check("alt_drain", 32'(exp_q.size()), 32'd0);

        // CPU arrives mid debug packet and must wait for its last byte
        clear_pkts();
        add_pkt(1, 5, 64'hC5C4C3C2C1);
        add_pkt(0, 2, 64'hD2D1);
        model_arb(1);
        fork
            send_pkt(1, 0, 0, 5, 3);
            begin
                repeat (4) @(posedge clk);
                #1 send_pkt(0, 0, 0, 2, 0);
            end
        join
        wait_idle("lock_idle");
        check("lock_drain", 32'(exp_q.size()), 32'd0);
        check("lock_no_ready", 32'(bad_ready), 32'd0);

        // i_en dropped after the first byte: packet completes, no new grant
        clear_pkts();
        add_pkt(0, 4, 64'hE4E3E2E1);
        model_arb(0);
        fork
            send_pkt(0, 0, 0, 4, 1);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!tx_stb && n < 100);
                en = 1'b0;
            end
        join
        wait_idle("en0_idle");
        vld[1] = 1'b1; dat[1] = 8'h77; lst[1] = 1'b1;
        repeat (30) @(negedge clk);
        check("en0_owner", 32'(owner), 32'd0);
        check("en0_dbg_ready", 32'(dbg_ready), 32'd0);
        vld[1] = 1'b0;
        en = 1'b1;
        check("en0_drain", 32'(exp_q.size()), 32'd0);

        // owner stalls without a last byte
        busy_len = 3;
        clear_pkts();
        add_pkt(0, 2, 64'h2211);
        model_arb(0);
        sync();
        send_pkt(0, 0, 0, 1, 0);
`ifdef TX_ARB_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 100);
        d = 0;
        do begin
            @(negedge clk);
            d++;
        end while (!timeout && d < 100);
        check("tmo_delay", 32'(d), 32'd8);
        check("tmo_owner", 32'(owner), 32'd0);
`else
        repeat (120) @(negedge clk);
        check("stall_owner", 32'(owner), 32'd1);
        check("stall_cpu_ready", 32'(cpu_ready), 32'd1);
`endif
        check("tmo_pulses", 32'(n_tmo), 32'(EXP_TMO));
        sync();
        send_pkt(0, 0, 1, 2, 0);
        wait_idle("stall_idle");
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // reset in the strobe cycle, then priority must be back on CPU
        sync();
        vld[0] = 1'b1; dat[0] = 8'h31; lst[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 100);
        @(posedge clk);
        #1 vld[0] = 1'b0;
        #1 check("pre_rst_stb", 32'(tx_stb), 32'd1);
        rst_n = 1'b0;
        #1 check("mid_rst_stb", 32'(tx_stb), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_data", 32'(tx_data), 32'd0);
        check("mid_rst_ready", 32'(cpu_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_pkts();
        add_pkt(0, 1, 64'h41);
        add_pkt(1, 1, 64'h42);
        model_arb(0);
        run_all(0);
        wait_idle("post_rst_idle");
        check("post_rst_drain", 32'(exp_q.size()), 32'd0);

        // randomized packet mixes with random gaps and busy lengths
        busy_rnd = 1'b1;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            clear_pkts();
            for (int s = 0; s < 2; s++)
                for (int k = int'($urandom_range(6, 2)); k > 0; k--)
                    add_pkt(s, int'($urandom_range(5, 1)), {$urandom, $urandom});
            model_arb(0);
            run_all(3);
            wait_idle("rnd_idle");
            check("rnd_drain", 32'(exp_q.size()), 32'd0);
        end
        check("ready_rule", 32'(bad_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
